// File: rtl/updn_counter_pkg.sv
// Shared constants, op codes and the default-bound helper for the up/down counter.
package updn_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_CLR  = 2'd1,
    OP_LOAD = 2'd2,
    OP_STEP = 2'd3
  } op_t;

  // Largest value representable in w bits, safe for w up to 32.
  function automatic int unsigned max_for_width(input int unsigned w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/param_updown_counter_next_calc.sv
// Combinational next-count and bound-event logic; the macro UPDN_SAT_EN selects
// saturating bound handling, otherwise bound events wrap modulo MAX_VAL+1.
module updn_next_calc
  import updn_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned MAX_VAL = max_for_width(WIDTH)
) (
  input  logic [WIDTH-1:0] count,
  input  op_t              op,
  input  logic             up_down,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             up_evt,
  output logic             dn_evt
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);

  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] load_ext;
  logic [WIDTH:0] next_ext;

  assign count_ext = {1'b0, count};
  assign load_ext  = {1'b0, load_val};

  always_comb begin
    next_ext = count_ext;
    up_evt   = 1'b0;
    dn_evt   = 1'b0;
    unique case (op)
      OP_CLR:  next_ext = '0;
      OP_LOAD: next_ext = (load_ext <= MAX_EXT) ? load_ext : MAX_EXT;
      OP_STEP: begin
        if (up_down) begin
          if (count_ext >= MAX_EXT) begin
            up_evt = 1'b1;
`ifdef UPDN_SAT_EN
            next_ext = MAX_EXT;
`else
            next_ext = '0;
`endif
          end else begin
            next_ext = count_ext + 1'b1;
          end
        end else begin
          if (count_ext == '0) begin
            dn_evt = 1'b1;
`ifdef UPDN_SAT_EN
            next_ext = '0;
`else
            next_ext = MAX_EXT;
`endif
          end else begin
            next_ext = count_ext - 1'b1;
          end
        end
      end
      default: next_ext = count_ext;
    endcase
  end

  assign next_count = next_ext[WIDTH-1:0];

endmodule

// File: rtl/param_updown_counter.sv
// Bounded up/down counter with load/clear, terminal-count pulse and sticky
// overflow/underflow flags. Bound behaviour selected by UPDN_SAT_EN (saturate) or wrap.
module param_updown_counter
  import updn_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned MAX_VAL = max_for_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  op_t              op;
  logic [WIDTH-1:0] next_count;
  logic             up_evt;
  logic             dn_evt;

  assign op = clr  ? OP_CLR  :
              load ? OP_LOAD :
              en   ? OP_STEP : OP_HOLD;

  updn_next_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next_calc (
    .count      (count),
    .op         (op),
    .up_down    (up_down),
    .load_val   (load_val),
    .next_count (next_count),
    .up_evt     (up_evt),
    .dn_evt     (dn_evt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      count <= next_count;
      tc    <= up_evt | dn_evt;
      // Clear wins over any bound event; otherwise the flags are sticky.
      ovf   <= (op == OP_CLR) ? 1'b0 : (ovf | up_evt);
      udf   <= (op == OP_CLR) ? 1'b0 : (udf | dn_evt);
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter at WIDTH=4, MAX_VAL=9; expectations
// follow the build (UPDN_SAT_EN saturates, otherwise wraps).
module tb_param_updown_counter;

  localparam int W = 4;
  localparam int M = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up_down = 1'b1;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         tc;
  logic         ovf;
  logic         udf;

  int checks = 0;
  int failures = 0;

  param_updown_counter #(.WIDTH(W), .MAX_VAL(M)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_down  (up_down),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf),
    .udf      (udf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; clr = 1'b0; load = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    idle(); load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_clr();
    idle(); clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0 || udf !== 1'b0) begin
      failures++; $display("FAIL reset_init: got count=%0d tc=%b ovf=%b udf=%b want 0 0 0 0", count, tc, ovf, udf); end
    rst = 1'b0;
    do_load(4'd5);
    checks++; if (count !== 4'd5) begin
      failures++; $display("FAIL reset_preload: got count=%0d want 5", count); end
    en = 1'b1; up_down = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0 || udf !== 1'b0) begin
      failures++; $display("FAIL reset_async: got count=%0d tc=%b ovf=%b udf=%b want 0 0 0 0", count, tc, ovf, udf); end
    #1 rst = 1'b0;
    tick();
    checks++; if (count !== 4'd1) begin
      failures++; $display("FAIL reset_first_step: got count=%0d want 1", count); end
    idle();
  endtask

  task automatic test_up_bound();
    logic [W-1:0] exp_c2, exp_c3;
    logic         exp_tc3;
`ifdef UPDN_SAT_EN
    exp_c2 = 4'd9; exp_c3 = 4'd9; exp_tc3 = 1'b1;
`else
    exp_c2 = 4'd0; exp_c3 = 4'd1; exp_tc3 = 1'b0;
`endif
    do_clr();
    do_load(4'd8);
    en = 1'b1; up_down = 1'b1;
    tick();
    checks++; if (count !== 4'd9 || tc !== 1'b0 || ovf !== 1'b0) begin
      failures++; $display("FAIL up_step1: got count=%0d tc=%b ovf=%b want 9 0 0", count, tc, ovf); end
    tick();
    checks++; if (count !== exp_c2 || tc !== 1'b1 || ovf !== 1'b1 || udf !== 1'b0) begin
      failures++; $display("FAIL up_bound: got count=%0d tc=%b ovf=%b udf=%b want %0d 1 1 0", count, tc, ovf, udf, exp_c2); end
    tick();
    checks++; if (count !== exp_c3 || tc !== exp_tc3 || ovf !== 1'b1) begin
      failures++; $display("FAIL up_after: got count=%0d tc=%b ovf=%b want %0d %b 1", count, tc, ovf, exp_c3, exp_tc3); end
    idle();
    tick();
    checks++; if (count !== exp_c3 || tc !== 1'b0 || ovf !== 1'b1) begin
      failures++; $display("FAIL up_hold: got count=%0d tc=%b ovf=%b want %0d 0 1", count, tc, ovf, exp_c3); end
  endtask

  task automatic test_down_bound();
    logic [W-1:0] exp_c2, exp_c3;
    logic         exp_tc3;
`ifdef UPDN_SAT_EN
    exp_c2 = 4'd0; exp_c3 = 4'd0; exp_tc3 = 1'b1;
`else
    exp_c2 = 4'd9; exp_c3 = 4'd8; exp_tc3 = 1'b0;
`endif
    do_clr();
    checks++; if (count !== 4'd0 || ovf !== 1'b0 || udf !== 1'b0 || tc !== 1'b0) begin
      failures++; $display("FAIL clr_flags: got count=%0d tc=%b ovf=%b udf=%b want 0 0 0 0", count, tc, ovf, udf); end
    do_load(4'd1);
    en = 1'b1; up_down = 1'b0;
    tick();
    checks++; if (count !== 4'd0 || tc !== 1'b0 || udf !== 1'b0) begin
      failures++; $display("FAIL dn_step1: got count=%0d tc=%b udf=%b want 0 0 0", count, tc, udf); end
    tick();
    checks++; if (count !== exp_c2 || tc !== 1'b1 || udf !== 1'b1 || ovf !== 1'b0) begin
      failures++; $display("FAIL dn_bound: got count=%0d tc=%b udf=%b ovf=%b want %0d 1 1 0", count, tc, udf, ovf, exp_c2); end
    tick();
    checks++; if (count !== exp_c3 || tc !== exp_tc3 || udf !== 1'b1) begin
      failures++; $display("FAIL dn_after: got count=%0d tc=%b udf=%b want %0d %b 1", count, tc, udf, exp_c3, exp_tc3); end
    idle();
  endtask

  task automatic test_priority();
    // udf is still set from the previous test; load must keep it, clr must drop it
    do_load(4'd3);
    checks++; if (count !== 4'd3 || udf !== 1'b1 || tc !== 1'b0) begin
      failures++; $display("FAIL load_keeps_flag: got count=%0d udf=%b tc=%b want 3 1 0", count, udf, tc); end
    clr = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1; up_down = 1'b1;
    tick();
    checks++; if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0 || udf !== 1'b0) begin
      failures++; $display("FAIL prio_clr: got count=%0d tc=%b ovf=%b udf=%b want 0 0 0 0", count, tc, ovf, udf); end
    idle();
    do_load(4'd12);
    checks++; if (count !== 4'd9 || tc !== 1'b0) begin
      failures++; $display("FAIL load_clamp: got count=%0d tc=%b want 9 0", count, tc); end
    load = 1'b1; load_val = 4'd2; en = 1'b1; up_down = 1'b1;
    tick();
    checks++; if (count !== 4'd2 || tc !== 1'b0 || ovf !== 1'b0) begin
      failures++; $display("FAIL prio_load_over_en: got count=%0d tc=%b ovf=%b want 2 0 0", count, tc, ovf); end
    idle();
  endtask

  task automatic test_direction();
    logic [W-1:0] exp_seq [4] = '{4'd5, 4'd4, 4'd5, 4'd4};
    do_load(4'd4);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_down = (i % 2 == 0);
      tick();
      checks++; if (count !== exp_seq[i] || tc !== 1'b0) begin
        failures++; $display("FAIL dir_alt[%0d]: got count=%0d tc=%b want %0d 0", i, count, tc, exp_seq[i]); end
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up_down = ~up_down;
      tick();
      checks++; if (count !== 4'd4 || tc !== 1'b0) begin
        failures++; $display("FAIL en_hold[%0d]: got count=%0d tc=%b want 4 0", i, count, tc); end
    end
  endtask

  initial begin
    test_reset();
    test_up_bound();
    test_down_bound();
    test_priority();
    test_direction();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: upper count bound, legal range 1..2**WIDTH-1.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 en  input  1: count enable; a step occurs only when high.
REQ-006 up_down  input  1: direction; 1 = increment, 0 = decrement.
REQ-007 clr  input  1: synchronous clear to 0.
REQ-008 load  input  1: synchronous load of load_val.
REQ-009 load_val  input  WIDTH: value for load.
REQ-010 count  output  WIDTH: registered counter value.
REQ-011 tc  output  1: registered terminal-count event pulse.
REQ-012 ovf  output  1: sticky flag, set by any upward bound event.
REQ-013 udf  output  1: sticky flag, set by any downward bound event.

Function
REQ-014 Per-edge priority SHALL be clr > load > en; lower-priority requests in the same cycle are ignored.
REQ-015 clr SHALL set count=0 and clear tc, ovf and udf in the next cycle.
REQ-016 load SHALL set count=load_val when load_val<=MAX_VAL, else count=MAX_VAL; tc SHALL be 0 and ovf/udf SHALL hold.
REQ-017 en with up_down=1 and count<MAX_VAL SHALL increment count by 1; en with up_down=0 and count>0 SHALL decrement count by 1.
REQ-018 Upward bound event: en=1, up_down=1, count==MAX_VAL; downward bound event: en=1, up_down=0, count==0.
REQ-019 Bound events SHALL resolve per REQ-027/REQ-028.
REQ-020 tc SHALL be 1 for exactly the cycle after a bound event and 0 otherwise; back-to-back bound events SHALL keep tc high continuously.
REQ-021 ovf SHALL set on an upward bound event, udf on a downward one; both SHALL hold until clr or rst.
REQ-022 en=0 SHALL hold count, and tc SHALL be 0 in the next cycle.
REQ-023 A direction change SHALL take effect on the same edge it is sampled, with no dead cycle.
REQ-024 Intermediate arithmetic SHALL be WIDTH+1 bits; count SHALL never hold a value above MAX_VAL.

Reset
REQ-025 rst assertion SHALL immediately force count=0, tc=0, ovf=0 and udf=0, independent of clk.
REQ-026 Reset SHALL abort any in-progress load, clear or step; the first step SHALL occur on the first rising edge with rst low.

Configuration
REQ-027 Macro UPDN_SAT_EN defined: a bound event SHALL hold count at MAX_VAL (up) or 0 (down), i.e. saturate.
REQ-028 Macro UPDN_SAT_EN undefined: a bound event SHALL wrap count, MAX_VAL->0 going up and 0->MAX_VAL going down (modulo MAX_VAL+1).
REQ-029 tc, ovf and udf SHALL behave identically in both builds.

Structure
REQ-030 Package updn_counter_pkg SHALL hold the default WIDTH constant and a derived-MAX helper function.
REQ-031 Package updn_counter_pkg SHALL hold a 2-bit operation-code typedef: OP_HOLD, OP_CLR, OP_LOAD, OP_STEP.
REQ-032 Sub-module updn_next_calc SHALL be combinational and compute next count and bound-event flags from count, op code and direction; the top SHALL hold only the registers.

Verification (WIDTH=4, MAX_VAL=9)
REQ-033 Reset: rst pulse mid-count at count=5 -> count=0, tc=0, ovf=0, udf=0 with no clk edge required.
REQ-034 Wrap build: en=1, up_down=1 from 8 -> sequence 9, 0, 1; tc=1 only in the cycle count=0; ovf=1 thereafter.
REQ-035 Saturate build: en=1, up_down=0 from 1 -> sequence 0, 0, 0; tc=1 in both cycles after the held events; udf=1.
REQ-036 Priority: clr=1, load=1, load_val=7, en=1 in the same cycle -> count=0 and flags cleared; load_val=12 alone -> count=9.
REQ-037 Direction: alternate up_down every cycle from 4 with en=1 -> sequence 5, 4, 5, 4; en=0 for 3 cycles -> count holds 4, tc=0.
